clkgen_nco: RTL and testbench

CLKGEN_NCO -- requirements
Module: clkgen_nco

---
 rtl/clkgen_nco.sv | 171 +++++++++++++++++
 tb/tb_clkgen_nco.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkgen_nco.sv
// -----------------------------------------------------------------------------
// clkgen_nco
//
// Multi-channel numerically controlled clock-enable generator. Each channel
// adds its step to a phase accumulator on every refclk edge. A carry out of
// the top bit becomes a one-cycle pulse on cen_out[i], so the average pulse
// rate is f_refclk * step / 2^ACC_W. A small FSM (SETTLE / LOCKED / UPDATE)
// gates the pulses while the rates are being reprogrammed. The accumulators
// keep running in every FSM state.
//
// Build option:
//   CLKGEN_NCO_PHASE_ALIGN_EN - when defined, a valid reconfiguration clears
//                               every channel's accumulator, so all channels
//                               restart phase-aligned. When not defined, only
//                               the target channel's accumulator is cleared.
//
// Ports:
//   refclk       in   sole clock, rising edge
//   rst          in   synchronous, active-high reset
//   cfg_valid    in   reconfiguration request
//   cfg_ready    out  reconfiguration accept (high only in LOCKED)
//   cfg_chan     in   target channel index
//   cfg_step     in   new step value for the target channel
//   cen_out      out  registered clock-enable pulse, one bit per channel
//   locked       out  high when all channels run at their programmed rate
//   dbg_state_o  out  current FSM state, for debug and checkers
//
// Handshake: a request transfers on a rising edge where cfg_valid and
// cfg_ready are both high. The requester holds cfg_valid and the payload
// stable until that edge. cfg_valid while cfg_ready is low is ignored and is
// not queued.
// -----------------------------------------------------------------------------
module clkgen_nco #(
    parameter int               CHANNELS    = 2,
    parameter int               ACC_W       = 32,
    parameter int               LOCK_CYCLES = 1024,
    parameter logic [ACC_W-1:0] INIT_STEP   = {1'b1, {(ACC_W-1){1'b0}}},
    localparam int              CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [ACC_W-1:0]    cfg_step,
    output logic [CHANNELS-1:0] cen_out,
    output logic                locked,
    output logic [1:0]          dbg_state_o
);

    localparam logic [1:0] SETTLE = 2'd0;
    localparam logic [1:0] LOCKED = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;

    // The settle counter only has to reach LOCK_CYCLES-1.
    localparam int              CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

`ifdef CLKGEN_NCO_PHASE_ALIGN_EN
    localparam bit PHASE_ALIGN = 1'b1;
`else
    localparam bit PHASE_ALIGN = 1'b0;
`endif

    logic [1:0]          state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [CHAN_W-1:0]   chan_q,     chan_d;
    logic [ACC_W-1:0]    new_step_q, new_step_d;
    logic [CHANNELS-1:0] cen_q,      cen_d;
    logic [ACC_W-1:0]    acc_q  [CHANNELS];
    logic [ACC_W-1:0]    acc_d  [CHANNELS];
    logic [ACC_W-1:0]    step_q [CHANNELS];
    logic [ACC_W-1:0]    step_d [CHANNELS];
    logic [ACC_W:0]      sum    [CHANNELS];
    logic [CHANNELS-1:0] chan_hit;
    logic                upd_valid;
    logic                pulse_en;

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chan_d     = chan_q;
        new_step_d = new_step_q;
        upd_valid  = 1'b0;
        case (state_q)
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = LOCKED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                // cfg_ready is high throughout LOCKED, so cfg_valid alone
                // completes the handshake here.
                if (cfg_valid) begin
                    chan_d     = cfg_chan;
                    new_step_d = cfg_step;
                    state_d    = UPDATE;
                end
            end
            UPDATE: begin
                // An out-of-range channel is accepted but changes nothing, so
                // the rates are still valid and no resettle is needed.
                if (int'(chan_q) < CHANNELS) begin
                    upd_valid = 1'b1;
                    cnt_d     = '0;
                    state_d   = SETTLE;
                end else begin
                    state_d   = LOCKED;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SETTLE;
            end
        endcase
    end

    // Pulses pass only when LOCKED both before and after this edge. The second
    // term keeps cen_out low during the UPDATE cycle that follows an accept.
    assign pulse_en = (state_q == LOCKED) && (state_d == LOCKED);

    // -------------------------------------------------------------------------
    // Phase accumulators
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sum[i]      = {1'b0, acc_q[i]} + {1'b0, step_q[i]};
            chan_hit[i] = upd_valid && (int'(chan_q) == i);
            step_d[i]   = chan_hit[i] ? new_step_q : step_q[i];
            // Clearing overrides this cycle's addition, so the channel restarts
            // from phase zero on the first SETTLE cycle.
            acc_d[i]    = (chan_hit[i] || (upd_valid && PHASE_ALIGN)) ? '0 : sum[i][ACC_W-1:0];
            cen_d[i]    = sum[i][ACC_W] & pulse_en;
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= SETTLE;
            cnt_q      <= '0;
            chan_q     <= '0;
            new_step_q <= '0;
            cen_q      <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i]  <= '0;
                step_q[i] <= INIT_STEP;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chan_q     <= chan_d;
            new_step_q <= new_step_d;
            cen_q      <= cen_d;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i]  <= acc_d[i];
                step_q[i] <= step_d[i];
            end
        end
    end

    assign cen_out     = cen_q;
    assign locked      = (state_q == LOCKED);
    assign cfg_ready   = (state_q == LOCKED);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_clkgen_nco.sv
// -----------------------------------------------------------------------------
// tb_clkgen_nco
//
// Self-checking bench for clkgen_nco. A cycle model of the generator predicts
// {state, cfg_ready, locked, cen_out} after every refclk edge. The prediction
// is pushed to exp_q at the edge and popped and compared at the following
// falling edge. Scenario checks count lock latency and pulse rates against
// constants.
//
// CHANNELS is 3 so that the 2-bit cfg_chan can carry the out-of-range
// index 3. Channels 0 and 1 are the ones under test.
// -----------------------------------------------------------------------------
module tb_clkgen_nco;

    localparam int CH = 3;
    localparam int AW = 32;
    localparam int LC = 16;
    localparam int SW = 2 + 1 + 1 + CH;

    localparam int S_SETTLE = 0;
    localparam int S_LOCKED = 1;
    localparam int S_UPDATE = 2;

`ifdef CLKGEN_NCO_PHASE_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_chan;
    logic [AW-1:0] cfg_step;
    logic [CH-1:0] cen_out;
    logic          locked;
    logic [1:0]    dbg_state;

    clkgen_nco #(
        .CHANNELS   (CH),
        .ACC_W      (AW),
        .LOCK_CYCLES(LC)
    ) dut (
        .refclk     (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_chan   (cfg_chan),
        .cfg_step   (cfg_step),
        .cen_out    (cen_out),
        .locked     (locked),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [SW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rst_cyc  = 0;

    // ---------------- model state ----------------
    int            m_state;
    int            m_cnt;
    logic [AW-1:0] m_acc  [CH];
    logic [AW-1:0] m_step [CH];
    logic [1:0]    m_chan;
    logic [AW-1:0] m_stepc;
    logic [CH-1:0] m_cen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [AW:0]   s;
        logic          gate;
        logic [CH-1:0] cen_n;
        logic [SW-1:0] e;
        if (rst) begin
            m_state = S_SETTLE;
            m_cnt   = 0;
            m_cen   = '0;
            m_chan  = '0;
            m_stepc = '0;
            for (int i = 0; i < CH; i++) begin
                m_acc[i]  = '0;
                m_step[i] = 32'h8000_0000;
            end
            rst_cyc = cyc;
        end else begin
            gate = (m_state == S_LOCKED) && !cfg_valid;
            for (int i = 0; i < CH; i++) begin
                s        = {1'b0, m_acc[i]} + {1'b0, m_step[i]};
                cen_n[i] = s[AW] & gate;
                m_acc[i] = s[AW-1:0];
            end
            m_cen = cen_n;
            case (m_state)
                S_SETTLE: if (m_cnt == LC - 1) m_state = S_LOCKED; else m_cnt++;
                S_LOCKED: if (cfg_valid) begin
                    m_chan  = cfg_chan;
                    m_stepc = cfg_step;
                    m_state = S_UPDATE;
                end
                default: begin
                    if (int'(m_chan) < CH) begin
                        m_step[m_chan] = m_stepc;
                        for (int i = 0; i < CH; i++)
                            if (ALIGN || i == int'(m_chan)) m_acc[i] = '0;
                        m_cnt   = 0;
                        m_state = S_SETTLE;
                    end else begin
                        m_state = S_LOCKED;
                    end
                end
            endcase
        end
        e = {2'(m_state), m_state == S_LOCKED, m_state == S_LOCKED, m_cen};
        exp_q.push_back(e);
    endtask

    // One refclk cycle: model at the rising edge, compare at the falling edge.
    task automatic tick();
        logic [SW-1:0] e;
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("cycle_outputs", 32'({dbg_state, cfg_ready, locked, cen_out}), 32'(e));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input logic [1:0] ch, input logic [AW-1:0] st);
        int n;
        n = 0;
        cfg_valid = 1'b1;
        cfg_chan  = ch;
        cfg_step  = st;
        while (cfg_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("cfg_accept_timeout", 32'd0, 32'd1);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_lock(output int low, output int rdy_low);
        low     = 0;
        rdy_low = 0;
        while (locked !== 1'b1 && low < 200) begin
            low++;
            if (cfg_ready !== 1'b1) rdy_low++;
            tick();
        end
    endtask

    task automatic observe(input int n, output int c0, output int c1, output int lk,
                           output int diff01, output int mis0);
        c0 = 0; c1 = 0; lk = 0; diff01 = 0; mis0 = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            c0 += int'(cen_out[0]);
            c1 += int'(cen_out[1]);
            lk += int'(locked);
            if (cen_out[0] != cen_out[1]) diff01++;
            // With the reset step, channel 0 carries on even edges after reset.
            if (cen_out[0] && ((cyc - rst_cyc) % 2 != 0)) mis0++;
        end
    endtask

    task automatic idle_gap();
        int g;
        g = $urandom_range(0, 5);
        for (int k = 0; k < g; k++) tick();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int low, rlow, c0, c1, lk, d01, mis0, pre;

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_step  = '0;
        tick();
        tick();
        check("reset_outputs", 32'({cfg_ready, locked, cen_out}), 32'd0);
        rst = 1'b0;

        // Reset release: lock latency and default period-2 pulses.
        wait_lock(low, rlow);
        check("lock_after_reset", 32'(low), 32'(LC));
        observe(16, c0, c1, lk, d01, mis0);
        check("default_ch0_rate", 32'(c0), 32'd8);
        check("default_ch1_rate", 32'(c1), 32'd8);
        check("default_locked", 32'(lk), 32'd16);
        idle_gap();

        // Channel 1 to quarter rate.
        cfg_write(2'd1, 32'h4000_0000);
        wait_lock(low, rlow);
        check("ch1_update_locked_low", 32'(low), 32'(LC + 1));
        check("ch1_update_ready_low", 32'(rlow), 32'(LC + 1));
        observe(16, c0, c1, lk, d01, mis0);
        check("ch1_quarter_rate", 32'(c1), 32'd4);
        check("ch0_still_half", 32'(c0), 32'd8);
`ifndef CLKGEN_NCO_PHASE_ALIGN_EN
        check("ch0_phase_kept", 32'(mis0), 32'd0);
`endif
        idle_gap();

`ifdef CLKGEN_NCO_PHASE_ALIGN_EN
        // Both channels at quarter rate restart aligned.
        cfg_write(2'd0, 32'h4000_0000);
        wait_lock(low, rlow);
        check("align_locked_low", 32'(low), 32'(LC + 1));
        observe(16, c0, c1, lk, d01, mis0);
        check("align_ch0_rate", 32'(c0), 32'd4);
        check("align_coincide", 32'(d01), 32'd0);
`else
        // Rewriting the same step still clears and resettles.
        cfg_write(2'd1, 32'h4000_0000);
        wait_lock(low, rlow);
        check("same_step_resettle", 32'(low), 32'(LC + 1));
        observe(16, c0, c1, lk, d01, mis0);
        check("same_step_ch1_rate", 32'(c1), 32'd4);
        check("same_step_ch0_phase", 32'(mis0), 32'd0);
`endif
        idle_gap();

        // Out-of-range channel: single UPDATE cycle, nothing changes.
        cfg_write(2'd3, AW'($urandom));
        wait_lock(low, rlow);
        check("bad_chan_locked_low", 32'(low), 32'd1);
        observe(16, c0, c1, lk, d01, mis0);
        check("bad_chan_ch0_rate", 32'(c0), ALIGN ? 32'd4 : 32'd8);
        check("bad_chan_ch1_rate", 32'(c1), 32'd4);
        check("bad_chan_locked", 32'(lk), 32'd16);
`ifndef CLKGEN_NCO_PHASE_ALIGN_EN
        check("bad_chan_ch0_phase", 32'(mis0), 32'd0);
`endif
        idle_gap();

        // Step 0 silences channel 0.
        cfg_write(2'd0, 32'h0);
        wait_lock(low, rlow);
        check("step0_locked_low", 32'(low), 32'(LC + 1));
        observe(100, c0, c1, lk, d01, mis0);
        check("step0_no_pulses", 32'(c0), 32'd0);
        check("step0_locked", 32'(lk), 32'd100);
        idle_gap();

        // Reset 5 cycles into SETTLE; a request during SETTLE is ignored.
        cfg_write(2'd1, 32'h4000_0000);
        for (int k = 0; k < 5; k++) tick();
        rst       = 1'b1;
        cfg_valid = 1'b1;
        cfg_chan  = 2'd1;
        cfg_step  = 32'h0;
        tick();
        rst = 1'b0;
        pre = 0;
        for (int k = 0; k < 4; k++) begin
            if (locked !== 1'b1) pre++;
            tick();
        end
        cfg_valid = 1'b0;
        wait_lock(low, rlow);
        check("rst_mid_settle_lock", 32'(pre + low), 32'(LC));
        observe(16, c0, c1, lk, d01, mis0);
        check("rst_ch0_default", 32'(c0), 32'd8);
        check("rst_ch1_default", 32'(c1), 32'd8);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
